// File: rtl/rx_frame_buffer_ctrl.sv
// Receive frame buffer controller: captures one deserialised frame, holds it until released.
// Optional RX_FRAME_BUFFER_CTRL_PARTIAL_BYTE_EN enables storing and reporting a partial last byte.
module rx_frame_buffer_ctrl #(
  parameter int unsigned MAX_BYTES = 16,
  parameter int unsigned LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_soc,
  input  logic             in_eoc,
  input  logic             in_error,
  input  logic [7:0]       in_data,
  input  logic             in_data_valid,
  input  logic [2:0]       in_data_bits,
  output logic             frame_ready,
  output logic [LEN_W-1:0] frame_len,
  output logic [2:0]       frame_last_bits,
  output logic             frame_error,
  output logic             frame_overflow,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  input  logic             frame_release,
  output logic             frame_dropped
);

  localparam int unsigned AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RX      = 2'd1;
  localparam logic [1:0] READY   = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]       bits_q, bits_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             rel_q, rel_d;
  logic             ready_q, ready_d;
  logic             dropped_q, dropped_d;
  logic [7:0]       rd_data_q;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             start;
  logic             capture;
  logic [7:0]       mem [MAX_BYTES];

  // Next-state and frame bookkeeping; a restart (soc) clears before same-cycle data is applied
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    bits_d    = bits_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    rel_d     = rel_q;
    dropped_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    start     = 1'b0;
    capture   = 1'b0;
    ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_soc) begin
          start   = 1'b1;
          capture = 1'b1;
          state_d = RX;
        end
      end
      RX: begin
        start   = in_soc;
        capture = 1'b1;
      end
      READY: begin
        if (frame_release) begin
          if (in_soc) begin
            start   = 1'b1;
            capture = 1'b1;
            state_d = RX;
          end else begin
            state_d = IDLE;
          end
        end else if (in_soc) begin
          state_d   = DISCARD;
          rel_d     = 1'b0;
          dropped_d = 1'b1;
        end
      end
      DISCARD: begin
        if (in_soc) dropped_d = 1'b1;
        if (frame_release) rel_d = 1'b1;
        if (in_eoc) begin
          state_d = (rel_q || frame_release) ? IDLE : READY;
          rel_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      wr_ptr_d = '0;
      bits_d   = 3'd0;
      err_d    = 1'b0;
      ovf_d    = 1'b0;
    end

    if (capture) begin
      if (in_data_valid) begin
`ifdef RX_FRAME_BUFFER_CTRL_PARTIAL_BYTE_EN
        if (bits_d != 3'd0) err_d = 1'b1;
`else
        if (in_data_bits != 3'd0) err_d = 1'b1;
`endif
        if (wr_ptr_d < LEN_W'(MAX_BYTES)) begin
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_d[AW-1:0];
          wr_ptr_d  = wr_ptr_d + LEN_W'(1);
`ifdef RX_FRAME_BUFFER_CTRL_PARTIAL_BYTE_EN
          bits_d    = in_data_bits;
`endif
        end else begin
          ovf_d = 1'b1;
          err_d = 1'b1;
        end
      end
      if (in_error) err_d = 1'b1;
      if (in_eoc) state_d = READY;
    end

    // A release seen during DISCARD frees the held frame immediately
    ready_d = (state_d == READY) || ((state_d == DISCARD) && !rel_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      bits_q    <= 3'd0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rel_q     <= 1'b0;
      ready_q   <= 1'b0;
      dropped_q <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      bits_q    <= bits_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      rel_q     <= rel_d;
      ready_q   <= ready_d;
      dropped_q <= dropped_d;
      rd_data_q <= (rd_addr < wr_ptr_q) ? mem[rd_addr[AW-1:0]] : 8'h00;
    end
  end

  // Frame storage, no reset needed: reads beyond frame_len are masked to zero
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_data;
  end

  assign frame_ready     = ready_q;
  assign frame_len       = wr_ptr_q;
  assign frame_last_bits = bits_q;
  assign frame_error     = err_q;
  assign frame_overflow  = ovf_q;
  assign rd_data         = rd_data_q;
  assign frame_dropped   = dropped_q;

endmodule

// File: tb/tb_rx_frame_buffer_ctrl.sv
// Self-checking bench for rx_frame_buffer_ctrl against a queue-based frame model.
module tb_rx_frame_buffer_ctrl;

  localparam int MAXB = 16;
  localparam int LW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_soc, in_eoc, in_error, in_data_valid, frame_release;
  logic [7:0]    in_data;
  logic [2:0]    in_data_bits;
  logic          frame_ready, frame_error, frame_overflow, frame_dropped;
  logic [LW-1:0] frame_len;
  logic [2:0]    frame_last_bits;
  logic [LW-1:0] rd_addr;
  logic [7:0]    rd_data;

  rx_frame_buffer_ctrl #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
    .in_data(in_data), .in_data_valid(in_data_valid), .in_data_bits(in_data_bits),
    .frame_ready(frame_ready), .frame_len(frame_len), .frame_last_bits(frame_last_bits),
    .frame_error(frame_error), .frame_overflow(frame_overflow), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_release(frame_release), .frame_dropped(frame_dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;

  always @(posedge clk) if (frame_dropped === 1'b1) drop_cnt <= drop_cnt + 1;

  // Frame under construction and its expected result
  logic [7:0] fd[$];
  logic [2:0] fb[$];
  int         exp_len;
  logic       exp_ovf, exp_err;
  logic [2:0] exp_bits;
  logic [7:0] exp_mem [64];
  logic       rdy_pre_eoc;

  task automatic clr_in();
    in_soc = 1'b0; in_eoc = 1'b0; in_error = 1'b0; in_data_valid = 1'b0;
    in_data = 8'h00; in_data_bits = 3'd0; frame_release = 1'b0;
  endtask

  task automatic cyc(input logic soc, input logic eoc, input logic err, input logic dv,
                     input logic [7:0] d, input logic [2:0] b, input logic rel);
    in_soc = soc; in_eoc = eoc; in_error = err; in_data_valid = dv;
    in_data = d; in_data_bits = b; frame_release = rel;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
  endtask

  task automatic release_frame();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    clr_in();
  endtask

  task automatic read_byte(input int a, output logic [7:0] d);
    rd_addr = LW'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic gen_frame(input int n, input int last_bits);
    fd.delete(); fb.delete();
    for (int i = 0; i < n; i++) begin
      fd.push_back(8'($urandom));
      fb.push_back((i == n - 1) ? 3'(last_bits) : 3'd0);
    end
  endtask

  // Reference: stored bytes saturate at MAXB; error from pulses, overflow or illegal partial bytes
  task automatic model(input logic err_flag);
    int n;
    n = fd.size();
    exp_len = (n > MAXB) ? MAXB : n;
    exp_ovf = (n > MAXB);
    exp_err = exp_ovf | err_flag;
    for (int i = 0; i < n; i++) begin
`ifdef RX_FRAME_BUFFER_CTRL_PARTIAL_BYTE_EN
      if (i > 0 && fb[i-1] != 3'd0) exp_err = 1'b1;
`else
      if (fb[i] != 3'd0) exp_err = 1'b1;
`endif
    end
`ifdef RX_FRAME_BUFFER_CTRL_PARTIAL_BYTE_EN
    exp_bits = (exp_len > 0) ? fb[exp_len-1] : 3'd0;
`else
    exp_bits = 3'd0;
`endif
    for (int i = 0; i < exp_len; i++) exp_mem[i] = fd[i];
  endtask

  task automatic send_frame(input logic rel_on_soc, input logic err_mid,
                            input logic err_eoc, input logic gaps);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, rel_on_soc);
    for (int i = 0; i < fd.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle(1);
      if (err_mid && i == fd.size() / 2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, fd[i], fb[i], 1'b0);
    end
    if (err_mid && fd.size() == 0) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    rdy_pre_eoc = frame_ready;
    cyc(1'b0, 1'b1, err_eoc, 1'b0, 8'h00, 3'd0, 1'b0);
    clr_in();
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_addr = '0; clr_in();
    idle(3);
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %b want 0", frame_ready); end
    checks++; if (frame_len !== '0) begin errors++; $display("FAIL reset len: got %0d want 0", frame_len); end
    checks++; if (frame_last_bits !== 3'd0) begin errors++; $display("FAIL reset bits: got %0d want 0", frame_last_bits); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", frame_error); end
    checks++; if (frame_overflow !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b want 0", frame_overflow); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset rd_data: got %h want 00", rd_data); end
    checks++; if (frame_dropped !== 1'b0) begin errors++; $display("FAIL reset dropped: got %b want 0", frame_dropped); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_sizes();
    logic [7:0] got, want;
    for (int bits = 0; bits <= 16; bits++) begin
      gen_frame((bits + 7) / 8, bits % 8);
      model(1'b0);
      send_frame(1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (rdy_pre_eoc !== 1'b0) begin errors++; $display("FAIL size%0d early ready: got %b want 0", bits, rdy_pre_eoc); end
      checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL size%0d ready: got %b want 1", bits, frame_ready); end
      checks++; if (frame_len !== LW'((bits + 7) / 8)) begin errors++; $display("FAIL size%0d len: got %0d want %0d", bits, frame_len, (bits + 7) / 8); end
      checks++; if (frame_last_bits !== exp_bits) begin errors++; $display("FAIL size%0d bits: got %0d want %0d", bits, frame_last_bits, exp_bits); end
      checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL size%0d err: got %b want %b", bits, frame_error, exp_err); end
      checks++; if (frame_overflow !== 1'b0) begin errors++; $display("FAIL size%0d ovf: got %b want 0", bits, frame_overflow); end
      for (int i = 0; i <= exp_len; i++) begin
        read_byte(i, got);
        want = (i < exp_len) ? exp_mem[i] : 8'h00;
        checks++; if (got !== want) begin errors++; $display("FAIL size%0d rd[%0d]: got %h want %h", bits, i, got, want); end
      end
      release_frame();
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL size%0d release: ready got %b want 0", bits, frame_ready); end
      idle(1);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    gen_frame(20, 0);
    model(1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (frame_len !== LW'(MAXB)) begin errors++; $display("FAIL ovf len: got %0d want %0d", frame_len, MAXB); end
    checks++; if (frame_overflow !== 1'b1) begin errors++; $display("FAIL ovf flag: got %b want 1", frame_overflow); end
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL ovf err: got %b want 1", frame_error); end
    for (int i = 0; i < MAXB; i++) begin
      read_byte(i, got);
      checks++; if (got !== fd[i]) begin errors++; $display("FAIL ovf rd[%0d]: got %h want %h", i, got, fd[i]); end
    end
    release_frame(); idle(1);
  endtask

  task automatic test_error();
    logic [7:0] got;
    for (int k = 0; k < 2; k++) begin
      gen_frame(6, 0);
      model(1'b1);
      send_frame(1'b0, (k == 0), (k == 1), 1'b0);
      checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL error%0d flag: got %b want 1", k, frame_error); end
      checks++; if (frame_len !== LW'(6)) begin errors++; $display("FAIL error%0d len: got %0d want 6", k, frame_len); end
      for (int i = 0; i < 6; i++) begin
        read_byte(i, got);
        checks++; if (got !== exp_mem[i]) begin errors++; $display("FAIL error%0d rd[%0d]: got %h want %h", k, i, got, exp_mem[i]); end
      end
      release_frame(); idle(1);
    end
  endtask

  task automatic test_drop();
    logic [7:0] got;
    int d0;
    gen_frame(5, 0); model(1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    d0 = drop_cnt;
    gen_frame(4, 0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    checks++; if (drop_cnt !== d0 + 1) begin errors++; $display("FAIL drop count: got %0d want %0d", drop_cnt - d0, 1); end
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL drop held ready: got %b want 1", frame_ready); end
    checks++; if (frame_len !== LW'(5)) begin errors++; $display("FAIL drop held len: got %0d want 5", frame_len); end
    for (int i = 0; i < 5; i++) begin
      read_byte(i, got);
      checks++; if (got !== exp_mem[i]) begin errors++; $display("FAIL drop held rd[%0d]: got %h want %h", i, got, exp_mem[i]); end
    end
    release_frame();
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL drop release ready: got %b want 0", frame_ready); end
    idle(1);
    gen_frame(7, 0); model(1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (frame_len !== LW'(7)) begin errors++; $display("FAIL third len: got %0d want 7", frame_len); end
    for (int i = 0; i < 7; i++) begin
      read_byte(i, got);
      checks++; if (got !== exp_mem[i]) begin errors++; $display("FAIL third rd[%0d]: got %h want %h", i, got, exp_mem[i]); end
    end
    // Release while discarding: ready drops next cycle, trailing eoc returns to idle
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    release_frame();
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL discard release ready: got %b want 0", frame_ready); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    clr_in(); idle(2);
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL discard eoc ready: got %b want 0", frame_ready); end
    gen_frame(3, 0); model(1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (frame_ready !== 1'b1 || frame_len !== LW'(3)) begin errors++; $display("FAIL after discard: ready %b len %0d want 1/3", frame_ready, frame_len); end
    release_frame(); idle(1);
  endtask

  task automatic test_soc_release();
    logic [7:0] got;
    int d0;
    gen_frame(4, 0); model(1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    d0 = drop_cnt;
    gen_frame(6, 0); model(1'b0);
    send_frame(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL socrel ready: got %b want 1", frame_ready); end
    checks++; if (frame_len !== LW'(6)) begin errors++; $display("FAIL socrel len: got %0d want 6", frame_len); end
    checks++; if (drop_cnt !== d0) begin errors++; $display("FAIL socrel drops: got %0d want 0", drop_cnt - d0); end
    for (int i = 0; i < 6; i++) begin
      read_byte(i, got);
      checks++; if (got !== exp_mem[i]) begin errors++; $display("FAIL socrel rd[%0d]: got %h want %h", i, got, exp_mem[i]); end
    end
    release_frame(); idle(1);
  endtask

  task automatic test_partial_mid();
    fd.delete(); fb.delete();
    fd.push_back(8'hA1); fd.push_back(8'h1B); fd.push_back(8'h3C);
    fb.push_back(3'd0);  fb.push_back(3'd5);  fb.push_back(3'd0);
    model(1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL partial err: got %b want 1", frame_error); end
    checks++; if (frame_last_bits !== exp_bits) begin errors++; $display("FAIL partial bits: got %0d want %0d", frame_last_bits, exp_bits); end
    checks++; if (frame_len !== LW'(3)) begin errors++; $display("FAIL partial len: got %0d want 3", frame_len); end
    release_frame(); idle(1);
  endtask

  task automatic test_random();
    logic [7:0] got, want;
    logic       e;
    int         n;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 20);
      gen_frame(n, (n > 0) ? $urandom_range(0, 7) : 0);
      for (int i = 0; i + 1 < n; i++) if ($urandom_range(0, 7) == 0) fb[i] = 3'($urandom_range(1, 7));
      e = 1'($urandom_range(0, 3) == 0);
      model(e);
      send_frame(1'b0, e, 1'b0, 1'b1);
      checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d ready: got %b want 1", t, frame_ready); end
      checks++; if (frame_len !== LW'(exp_len)) begin errors++; $display("FAIL rnd%0d len: got %0d want %0d", t, frame_len, exp_len); end
      checks++; if (frame_last_bits !== exp_bits) begin errors++; $display("FAIL rnd%0d bits: got %0d want %0d", t, frame_last_bits, exp_bits); end
      checks++; if (frame_error !== exp_err) begin errors++; $display("FAIL rnd%0d err: got %b want %b", t, frame_error, exp_err); end
      checks++; if (frame_overflow !== exp_ovf) begin errors++; $display("FAIL rnd%0d ovf: got %b want %b", t, frame_overflow, exp_ovf); end
      for (int i = 0; i <= exp_len; i++) begin
        read_byte(i, got);
        want = (i < exp_len) ? exp_mem[i] : 8'h00;
        checks++; if (got !== want) begin errors++; $display("FAIL rnd%0d rd[%0d]: got %h want %h", t, i, got, want); end
      end
      release_frame(); idle(1);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 3'd0, 1'b0);
    clr_in(); rst = 1'b1;
    idle(1);
    checks++; if (frame_ready !== 1'b0 || frame_len !== '0 || frame_error !== 1'b0 || frame_overflow !== 1'b0)
      begin errors++; $display("FAIL midreset status: ready %b len %0d err %b ovf %b want all 0", frame_ready, frame_len, frame_error, frame_overflow); end
    checks++; if (frame_last_bits !== 3'd0 || rd_data !== 8'h00 || frame_dropped !== 1'b0)
      begin errors++; $display("FAIL midreset outputs: bits %0d rd %h drop %b want 0", frame_last_bits, rd_data, frame_dropped); end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    clr_in(); idle(3);
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL midreset eoc ready: got %b want 0", frame_ready); end
    checks++; if (frame_len !== '0) begin errors++; $display("FAIL midreset eoc len: got %0d want 0", frame_len); end
  endtask

  initial begin
    test_reset();
    test_sizes();
    test_overflow();
    test_error();
    test_drop();
    test_soc_release();
    test_partial_mid();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_buffer_ctrl.md
# rx_frame_buffer_ctrl

Sequences byte-level receive traffic from the deserialiser into a single-frame buffer and hands complete frames to the protocol layer. It tracks frame boundaries (soc/eoc), counts bytes and trailing bits, and latches error and overflow status. It holds the frame until the consumer releases it. Frames arriving while a frame is held are discarded and reported.

## Interface
Parameters:
- MAX_BYTES, 16, buffer depth in bytes; legal range 1..64.
- LEN_W, $clog2(MAX_BYTES+1), width of the byte-count output.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_soc  in  1  start-of-frame pulse from the deserialiser.
- in_eoc  in  1  end-of-frame pulse.
- in_error  in  1  error pulse; sticky for the current frame.
- in_data  in  8  received byte, LSB first on air.
- in_data_valid  in  1  one-cycle strobe; in_data/in_data_bits valid.
- in_data_bits  in  3  valid bits in in_data; 0 = 8 bits, 1..7 = partial byte.
- frame_ready  out  1  held frame available.
- frame_len  out  LEN_W  bytes stored, including a partial last byte.
- frame_last_bits  out  3  valid bits in the last byte (0 = full byte).
- frame_error  out  1  in_error seen, overflow, or illegal partial byte.
- frame_overflow  out  1  more than MAX_BYTES bytes received.
- rd_addr  in  LEN_W  buffer read address.
- rd_data  out  8  buffer byte at rd_addr, registered.
- frame_release  in  1  consumer done; frees the buffer.
- frame_dropped  out  1  one-cycle pulse when a frame is discarded because the buffer was held.

## Operation
- States: IDLE, RX, READY, DISCARD. Reset puts the block in IDLE.
- IDLE:
  - in_soc: go to RX; clear wr_ptr, error, overflow and last_bits.
- RX, on in_data_valid:
  - wr_ptr < MAX_BYTES: write buf[wr_ptr], wr_ptr++, last_bits = in_data_bits.
  - otherwise: set overflow and error; the byte is not stored and wr_ptr saturates.
- RX, other events:
  - in_data_valid when the previous byte was partial: set error (a partial byte is legal only as the last byte).
  - in_error: set sticky error.
  - in_soc: restart the frame with the IDLE clears; a simultaneous data/error in that cycle belongs to the new frame.
  - in_eoc: go to READY. Data, error or soc arriving in the same cycle as eoc are processed first.
- READY:
  - frame_ready=1; frame_len=wr_ptr; status outputs are stable.
  - frame_release: go to IDLE.
  - in_soc without release: go to DISCARD and pulse frame_dropped; the held frame is untouched.
  - in_soc with release in the same cycle: go to RX and start the new frame.
- DISCARD:
  - All inputs are ignored except eoc and soc.
  - in_eoc: return to READY.
  - frame_release: record the release; the next eoc goes to IDLE; frame_ready drops the cycle after release.
  - in_soc: pulse frame_dropped again and remain in DISCARD.
- A 0-byte frame (soc then eoc) gives frame_ready with frame_len=0 and last_bits=0.

## Timing
- Reset values: frame_ready=0, frame_len=0, frame_last_bits=0, frame_error=0, frame_overflow=0, rd_data=8'h00, frame_dropped=0.
- Reset mid-frame aborts the frame; no frame_ready follows.
- frame_ready rises one cycle after the in_eoc cycle.
- frame_ready falls one cycle after the frame_release cycle.
- rd_data latency is one cycle after rd_addr. Reads are valid only while frame_ready=1.
- rd_addr >= frame_len returns 8'h00.
- frame_dropped is registered: it pulses one cycle after the offending soc.
- frame_release outside READY/DISCARD is ignored.
- Back-to-back: soc in the cycle after eoc while READY goes to DISCARD.

## Configuration
- Macro: RX_FRAME_BUFFER_CTRL_PARTIAL_BYTE_EN.
- Defined: a partial final byte (in_data_bits 1..7) is stored, and frame_last_bits reports its bit count.
- Undefined:
  - Any in_data_valid with in_data_bits != 0 sets frame_error; the byte is still stored.
  - frame_last_bits is tied to 0.
  - The "partial byte then more data" check is removed.

## Test plan
- Sizes 0..16 bits, every size: soc, bytes, eoc -> frame_ready 1 cycle after eoc; frame_len = ceil(bits/8); frame_last_bits = bits%8; readback matches; frame_error=0.
- MAX_BYTES=16, 20-byte frame -> frame_len=16, frame_overflow=1, frame_error=1, bytes 0..15 intact.
- in_error pulse mid-frame, and again in the eoc cycle -> frame_error=1 both times; data still readable.
- Frame held; second soc..eoc arrives -> frame_dropped pulses once; held frame contents and frame_len unchanged. Release -> IDLE; a third frame is then received normally.
- soc and release in the same READY cycle -> the new frame is captured.
- Reset asserted mid-RX -> all outputs reset; the next eoc alone produces no frame_ready.
- 3 bytes with the 2nd partial (in_data_bits=5):
  - Macro defined: frame_error=1.
  - Macro undefined: frame_error=1 and frame_last_bits=0.
